// File: rtl/rsa_pkg.sv
// rtl/rsa_pkg.sv - shared FSM encoding, reset values and latency helper for the RSA modexp engine
package rsa_pkg;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_MUL  = 3'd2;
    localparam logic [2:0] S_UPD  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic RST_DONE = 1'b0;
    localparam logic RST_BUSY = 1'b0;
    localparam logic RST_ERR  = 1'b0;

    // k = number of square-and-multiply rounds executed (WIDTH in constant-time builds)
    function automatic int modexp_latency(input int width, input int k);
        return 2 + k * (width + 1);
    endfunction

endpackage

// File: rtl/rsa_modexp_if.sv
// rtl/rsa_modexp_if.sv - start/operand/result bundle between the bus wrapper and the modexp engine
interface rsa_modexp_if #(parameter int WIDTH = 32);

    logic             i_start;
    logic [WIDTH-1:0] i_base;
    logic [WIDTH-1:0] i_exp;
    logic [WIDTH-1:0] i_N;
    logic [WIDTH-1:0] o_result;
    logic             o_done;
    logic             o_busy;
    logic             o_err;

    modport master (
        output i_start, i_base, i_exp, i_N,
        input  o_result, o_done, o_busy, o_err
    );

    modport slave (
        input  i_start, i_base, i_exp, i_N,
        output o_result, o_done, o_busy, o_err
    );

endinterface

// File: rtl/rsa_modmul.sv
// rtl/rsa_modmul.sv - bit-serial interleaved modular multiplier, one MSB-first step per cycle
module rsa_modmul #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_n,
    output logic [WIDTH-1:0] o_r
);

    logic [WIDTH:0]   r_acc;
    logic [WIDTH:0]   r_a;
    logic [WIDTH:0]   r_n;
    logic [WIDTH-1:0] r_mplr;

    logic [WIDTH:0] w_dbl;
    logic [WIDTH:0] w_red1;
    logic [WIDTH:0] w_add;
    logic [WIDTH:0] w_red2;

    // acc and a stay below N, so every intermediate is below 2N and fits WIDTH+1 bits
    assign w_dbl  = r_acc << 1;
    assign w_red1 = (w_dbl >= r_n) ? (w_dbl - r_n) : w_dbl;
    assign w_add  = w_red1 + r_a;
    assign w_red2 = (w_add >= r_n) ? (w_add - r_n) : w_add;
    assign o_r    = r_acc[WIDTH-1:0];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_acc  <= '0;
            r_a    <= '0;
            r_n    <= '0;
            r_mplr <= '0;
        end else if (i_load) begin
            r_acc  <= '0;
            r_a    <= {1'b0, i_a};
            r_n    <= {1'b0, i_n};
            r_mplr <= i_b;
        end else begin
            r_acc  <= r_mplr[WIDTH-1] ? w_red2 : w_red1;
            r_mplr <= r_mplr << 1;
        end
    end

endmodule

// File: rtl/rsa_modexp.sv
// rtl/rsa_modexp.sv - right-to-left square-and-multiply modexp engine; RSA_MODEXP_EARLY_EXIT_EN enables early exit
module rsa_modexp
    import rsa_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic         i_clk,
    input  logic         i_rst,
    rsa_modexp_if.slave  bus
);

    localparam int CW = $clog2(WIDTH + 1);
`ifdef RSA_MODEXP_EARLY_EXIT_EN
    localparam bit EARLY_EXIT = 1'b1;
`else
    localparam bit EARLY_EXIT = 1'b0;
`endif

    logic [2:0]       r_state;
    logic [WIDTH-1:0] r_base, r_exp, r_n;
    logic [WIDTH-1:0] r_rv, r_ev, r_result;
    logic [CW-1:0]    r_step, r_cnt;
    logic             r_err_f, r_err, r_done, r_busy;

    logic             w_load, w_bad;
    logic [WIDTH-1:0] w_ra, w_rb, w_r_init, w_r_next, w_e_next, w_mul_a, w_mul_b;

    assign w_bad    = (r_n == '0) || (r_base >= r_n);
    assign w_r_init = (r_n == WIDTH'(1)) ? '0 : WIDTH'(1);
    assign w_r_next = r_ev[0] ? w_ra : r_rv;
    assign w_e_next = r_ev >> 1;

    // multipliers are primed in LOAD/UPD with the operands of the round that follows
    assign w_load  = (r_state == S_LOAD) || (r_state == S_UPD);
    assign w_mul_a = (r_state == S_LOAD) ? w_r_init : w_r_next;
    assign w_mul_b = (r_state == S_LOAD) ? r_base   : w_rb;

    rsa_modmul #(.WIDTH(WIDTH)) u_mul_r (
        .i_clk (i_clk), .i_rst (i_rst), .i_load (w_load),
        .i_a (w_mul_a), .i_b (w_mul_b), .i_n (r_n), .o_r (w_ra)
    );

    rsa_modmul #(.WIDTH(WIDTH)) u_mul_b (
        .i_clk (i_clk), .i_rst (i_rst), .i_load (w_load),
        .i_a (w_mul_b), .i_b (w_mul_b), .i_n (r_n), .o_r (w_rb)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_base   <= '0;
            r_exp    <= '0;
            r_n      <= '0;
            r_rv     <= '0;
            r_ev     <= '0;
            r_result <= '0;
            r_step   <= '0;
            r_cnt    <= '0;
            r_err_f  <= RST_ERR;
            r_err    <= RST_ERR;
            r_done   <= RST_DONE;
            r_busy   <= RST_BUSY;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    r_busy <= bus.i_start;
                    if (bus.i_start) begin
                        r_base  <= bus.i_base;
                        r_exp   <= bus.i_exp;
                        r_n     <= bus.i_N;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_step <= '0;
                    r_cnt  <= '0;
                    if (w_bad) begin
                        r_err_f <= 1'b1;
                        r_rv    <= '0;
                        r_state <= S_DONE;
                    end else begin
                        r_err_f <= 1'b0;
                        r_rv    <= w_r_init;
                        r_ev    <= r_exp;
                        r_state <= (EARLY_EXIT && (r_exp == '0)) ? S_DONE : S_MUL;
                    end
                end
                S_MUL: begin
                    r_step <= r_step + CW'(1);
                    if (r_step == CW'(WIDTH - 1))
                        r_state <= S_UPD;
                end
                S_UPD: begin
                    r_rv   <= w_r_next;
                    r_ev   <= w_e_next;
                    r_cnt  <= r_cnt + CW'(1);
                    r_step <= '0;
                    if ((r_cnt == CW'(WIDTH - 1)) || (EARLY_EXIT && (w_e_next == '0)))
                        r_state <= S_DONE;
                    else
                        r_state <= S_MUL;
                end
                S_DONE: begin
                    r_done   <= 1'b1;
                    r_result <= r_rv;
                    r_err    <= r_err_f;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.o_result = r_result;
    assign bus.o_done   = r_done;
    assign bus.o_busy   = r_busy;
    assign bus.o_err    = r_err;

endmodule

// File: tb/tb_rsa_modexp.sv
// tb/tb_rsa_modexp.sv - randomized self-checking bench for rsa_modexp against an arithmetic reference model
module tb_rsa_modexp;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    rsa_modexp_if #(.WIDTH(W)) bus();

    rsa_modexp #(.WIDTH(W)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_modexp(input logic [31:0] b, input logic [31:0] e, input logic [31:0] n);
        longint unsigned nn, r, bb;
        nn = 64'(n);
        if (nn == 1) return 32'd0;
        r  = 1;
        bb = 64'(b) % nn;
        for (int i = 0; i < W; i++) begin
            if (e[i]) r = (r * bb) % nn;
            bb = (bb * bb) % nn;
        end
        return r[31:0];
    endfunction

    function automatic int exp_lat(input logic [31:0] e);
        int k;
`ifdef RSA_MODEXP_EARLY_EXIT_EN
        k = 0;
        for (int i = 0; i < W; i++) if (e[i]) k = i + 1;
`else
        k = W;
`endif
        return 2 + k * (W + 1);
    endfunction

    task automatic start_op(input logic [31:0] b, input logic [31:0] e, input logic [31:0] n);
        @(negedge clk);
        bus.i_start = 1'b1;
        bus.i_base  = b;
        bus.i_exp   = e;
        bus.i_N     = n;
        @(negedge clk);
        bus.i_start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int lat);
        lat = -1;
        for (int i = 1; i <= budget; i++) begin
            @(posedge clk);
            #1;
            if (bus.o_done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic run_check(input string tag, input logic [31:0] b, input logic [31:0] e,
                             input logic [31:0] n, input logic [31:0] res, input logic err, input int lat_exp);
        int lat;
        start_op(b, e, n);
        wait_done(3000, lat);
        check({tag, "_lat"}, 64'(lat), 64'(lat_exp));
        check({tag, "_res"}, 64'(bus.o_result), 64'(res));
        check({tag, "_err"}, 64'(bus.o_err), 64'(err));
    endtask

    initial begin
        int lat, ndone;
        logic [31:0] b, e, n;

        bus.i_start = 1'b0;
        bus.i_base  = '0;
        bus.i_exp   = '0;
        bus.i_N     = '0;
        repeat (3) @(negedge clk);
        check("rst_result", 64'(bus.o_result), 64'd0);
        check("rst_done",   64'(bus.o_done),   64'd0);
        check("rst_busy",   64'(bus.o_busy),   64'd0);
        check("rst_err",    64'(bus.o_err),    64'd0);
        rst = 1'b0;

        start_op(32'd4, 32'd13, 32'd497);
        check("busy_after_start", 64'(bus.o_busy), 64'd1);
        wait_done(3000, lat);
        check("4p13_lat", 64'(lat), 64'(exp_lat(32'd13)));
        check("4p13_res", 64'(bus.o_result), 64'd445);
        check("4p13_err", 64'(bus.o_err), 64'd0);
        check("done_busy", 64'(bus.o_busy), 64'd1);
        @(posedge clk); #1;
        check("done_pulse", 64'(bus.o_done), 64'd0);
        check("idle_busy",  64'(bus.o_busy), 64'd0);

        run_check("2p10", 32'd2, 32'd10, 32'd1000, 32'd24, 1'b0, exp_lat(32'd10));
        run_check("5p0",  32'd5, 32'd0,  32'd7,    32'd1,  1'b0, exp_lat(32'd0));
        run_check("9p5m1", 32'd9, 32'd5, 32'd1,    32'd0,  1'b1, 2);
        run_check("0p5m1", 32'd0, 32'd5, 32'd1,    32'd0,  1'b0, exp_lat(32'd5));
        run_check("b_ge_n", 32'd10, 32'd3, 32'd7,  32'd0,  1'b1, 2);
        run_check("n_zero", 32'd3, 32'd3, 32'd0,   32'd0,  1'b1, 2);

        // start and operand changes while busy must be ignored
        start_op(32'd4, 32'd13, 32'd497);
        repeat (10) @(negedge clk);
        start_op(32'd2, 32'd10, 32'd1000);
        wait_done(3000, lat);
        check("ign_timeout", 64'(lat > 0), 64'd1);
        check("ign_res", 64'(bus.o_result), 64'd445);
        ndone = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (bus.o_done) ndone++;
        end
        check("ign_extra_done", 64'(ndone), 64'd0);

        // asynchronous reset in the middle of MUL
        start_op(32'd4, 32'd13, 32'd497);
        repeat (100) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_result", 64'(bus.o_result), 64'd0);
        check("mid_rst_busy",   64'(bus.o_busy),   64'd0);
        check("mid_rst_done",   64'(bus.o_done),   64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_check("post_rst", 32'd4, 32'd13, 32'd497, 32'd445, 1'b0, exp_lat(32'd13));

        for (int i = 0; i < 10; i++) begin
            n = $urandom;
            if (n < 32'd2) n = 32'd2;
            b = $urandom % n;
            e = $urandom;
            if (i % 3 == 0) e = e >> $urandom_range(0, 31);
            run_check($sformatf("rnd%0d", i), b, e, n, ref_modexp(b, e, n), 1'b0, exp_lat(e));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
